// File: rtl/axil_bridge_pkg.sv
// Shared types and response codes for the AXI4-Lite to I2C bridge front-end.
package axil_bridge_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int CMD_ADDR_WIDTH = 20;
    localparam int CMD_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        WR_COLLECT = 2'd0,
        WR_QUEUE   = 2'd1,
        WR_RESP    = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_QUEUE = 2'd1,
        R_WAIT  = 2'd2,
        R_RESP  = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic                      write;
        logic [CMD_ADDR_WIDTH-1:0] addr;
        logic [CMD_DATA_WIDTH-1:0] wdata;
    } bridge_cmd_t;

endpackage

// File: rtl/axil_i2c_slave_frontend_if.sv
// AXI4-Lite channel bundle between a bus master and the bridge front-end.
interface axil_i2c_slave_frontend_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RDATA_WIDTH = 8
);
    logic                   AWVALID;
    logic                   AWREADY;
    logic [ADDR_WIDTH-1:0]  AWADDR;
    logic                   WVALID;
    logic                   WREADY;
    logic [DATA_WIDTH-1:0]  WDATA;
    logic                   BVALID;
    logic                   BREADY;
    logic [1:0]             BRESP;
    logic                   ARVALID;
    logic                   ARREADY;
    logic [ADDR_WIDTH-1:0]  ARADDR;
    logic                   RVALID;
    logic                   RREADY;
    logic [1:0]             RRESP;
    logic [RDATA_WIDTH-1:0] RDATA;

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA
    );

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA
    );
endinterface

// File: rtl/bridge_cmd_fifo.sv
// Show-ahead command FIFO; full is judged before the pop of the same cycle.
module bridge_cmd_fifo
    import axil_bridge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(bridge_cmd_t)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_en;
    logic             w_pop_en;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_en = push && !full;
    assign w_pop_en  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    // NOTE: storage is deliberately not reset; clearing pointers and count is a full flush.
    always_ff @(posedge clk) begin
        if (w_push_en) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/axil_i2c_slave_frontend.sv
// AXI4-Lite slave front-end: decodes the bridge window, posts writes and
// queues single-outstanding reads into a command FIFO toward the I2C engine.
module axil_i2c_slave_frontend
    import axil_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH        = 32,
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    RDATA_WIDTH       = 8,
    parameter int                    OUTPUT_ADDR_WIDTH = 20,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR         = 32'h4000_0000,
    parameter int                    CMD_DEPTH         = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    axil_i2c_slave_frontend_if.slave     s_axil,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic                         cmd_write,
    output logic [OUTPUT_ADDR_WIDTH-1:0] cmd_addr,
    output logic [DATA_WIDTH-1:0]        cmd_wdata,
    input  logic                         rsp_valid,
    input  logic [RDATA_WIDTH-1:0]       rsp_rdata,
    input  logic                         rsp_err
);
    localparam int CMD_W = 1 + OUTPUT_ADDR_WIDTH + DATA_WIDTH;

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:OUTPUT_ADDR_WIDTH] == BASE_ADDR[ADDR_WIDTH-1:OUTPUT_ADDR_WIDTH];
    endfunction

    wr_state_t                    r_wr_state;
    logic                         r_aw_held, r_w_held;
    logic                         r_awready, r_wready;
    logic [ADDR_WIDTH-1:0]        r_awaddr;
    logic [DATA_WIDTH-1:0]        r_wdata;
    logic                         r_bvalid;
    logic [1:0]                   r_bresp;

    rd_state_t                    r_rd_state;
    logic                         r_arready;
    logic                         r_rd_hit;
    logic [OUTPUT_ADDR_WIDTH-1:0] r_rd_addr;
    logic                         r_rvalid;
    logic [1:0]                   r_rresp;
    logic [RDATA_WIDTH-1:0]       r_rdata;

    logic                         w_aw_hs, w_w_hs, w_ar_hs;
    logic                         w_wr_push, w_rd_push;
    logic                         w_fifo_full, w_fifo_empty;
    logic [CMD_W-1:0]             w_fifo_din, w_fifo_dout, w_head;

    assign w_aw_hs = s_axil.AWVALID && r_awready;
    assign w_w_hs  = s_axil.WVALID && r_wready;
    assign w_ar_hs = s_axil.ARVALID && r_arready;

    // Write has priority; a read push in the same cycle is deferred.
    assign w_wr_push = (r_wr_state == WR_QUEUE) && !w_fifo_full;
    assign w_rd_push = (r_rd_state == R_QUEUE) && r_rd_hit && !w_fifo_full && !w_wr_push;

    always_comb begin
        // NOTE: a default assignment first keeps this purely combinational (no latch).
        w_fifo_din = {1'b0, r_rd_addr, {DATA_WIDTH{1'b0}}};
        if (w_wr_push) w_fifo_din = {1'b1, r_awaddr[OUTPUT_ADDR_WIDTH-1:0], r_wdata};
    end

    bridge_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .push  (w_wr_push || w_rd_push),
        .pop   (cmd_ready),
        .din   (w_fifo_din),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .dout  (w_fifo_dout)
    );

    // Head is masked while empty so flushed or never-written storage stays off the port.
    assign w_head    = w_fifo_empty ? '0 : w_fifo_dout;
    assign cmd_valid = !w_fifo_empty;
    assign cmd_write = w_head[CMD_W-1];
    assign cmd_addr  = w_head[CMD_W-2 -: OUTPUT_ADDR_WIDTH];
    assign cmd_wdata = w_head[DATA_WIDTH-1:0];

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wr_state <= WR_COLLECT;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                WR_COLLECT: begin
                    r_awready <= !r_aw_held && !w_aw_hs;
                    r_wready  <= !r_w_held && !w_w_hs;
                    if (w_aw_hs) begin
                        r_awaddr  <= s_axil.AWADDR;
                        r_aw_held <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= s_axil.WDATA;
                        r_w_held <= 1'b1;
                    end
                    if (r_aw_held && r_w_held) begin
                        if (in_window(r_awaddr)) begin
                            r_wr_state <= WR_QUEUE;
                        end else begin
                            r_bvalid   <= 1'b1;
                            r_bresp    <= RESP_DECERR;
                            r_wr_state <= WR_RESP;
                        end
                    end
                end
                WR_QUEUE: begin
                    if (!w_fifo_full) begin
                        r_bvalid   <= 1'b1;
                        r_bresp    <= RESP_OKAY;
                        r_wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_axil.BREADY) begin
                        r_bvalid   <= 1'b0;
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                        r_wr_state <= WR_COLLECT;
                    end
                end
                default: r_wr_state <= WR_COLLECT;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_rd_addr  <= '0;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    r_arready <= !w_ar_hs;
                    if (w_ar_hs) begin
                        r_rd_addr  <= s_axil.ARADDR[OUTPUT_ADDR_WIDTH-1:0];
                        r_rd_hit   <= in_window(s_axil.ARADDR);
                        r_rd_state <= R_QUEUE;
                    end
                end
                R_QUEUE: begin
                    if (!r_rd_hit) begin
                        r_rvalid   <= 1'b1;
                        r_rresp    <= RESP_DECERR;
                        r_rdata    <= '0;
                        r_rd_state <= R_RESP;
                    end else if (w_rd_push) begin
                        r_rd_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rsp_valid) begin
                        r_rvalid   <= 1'b1;
                        r_rdata    <= rsp_rdata;
                        r_rresp    <= rsp_err ? RESP_SLVERR : RESP_OKAY;
                        r_rd_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axil.RREADY) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    assign s_axil.AWREADY = r_awready;
    assign s_axil.WREADY  = r_wready;
    assign s_axil.BVALID  = r_bvalid;
    assign s_axil.BRESP   = r_bresp;
    assign s_axil.ARREADY = r_arready;
    assign s_axil.RVALID  = r_rvalid;
    assign s_axil.RRESP   = r_rresp;
    assign s_axil.RDATA   = r_rdata;
endmodule

// File: tb/tb_axil_i2c_slave_frontend.sv
// Scoreboard bench: stimulus queues expected cmd/B/R items, a negedge monitor pops and compares.
module tb_axil_i2c_slave_frontend;
    import axil_bridge_pkg::*;

    logic        ACLK    = 1'b0;
    logic        ARESETn = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [19:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    bridge_cmd_t exp_cmd[$];
    logic [1:0]  exp_b[$];
    logic [9:0]  exp_r[$];

    always #5 ACLK = ~ACLK;

    axil_i2c_slave_frontend_if axil ();

    axil_i2c_slave_frontend dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .s_axil    (axil),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bridge_cmd_t mk_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        bridge_cmd_t c;
        c.write = w;
        c.addr  = a[19:0];
        c.wdata = d;
        return c;
    endfunction

    // Monitor: a handshake seen at the negedge completes at the following posedge.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) check("cmd_unexpected", 1, 0);
                else begin
                    bridge_cmd_t e;
                    e = exp_cmd.pop_front();
                    check("cmd_write", cmd_write, e.write);
                    check("cmd_addr", cmd_addr, e.addr);
                    check("cmd_wdata", cmd_wdata, e.wdata);
                end
            end
            if (axil.BVALID && axil.BREADY) begin
                if (exp_b.size() == 0) check("b_unexpected", 1, 0);
                else check("bresp", axil.BRESP, exp_b.pop_front());
            end
            if (axil.RVALID && axil.RREADY) begin
                if (exp_r.size() == 0) check("r_unexpected", 1, 0);
                else check("rresp_rdata", {axil.RRESP, axil.RDATA}, exp_r.pop_front());
            end
        end
    end

    task automatic send_aw(input logic [31:0] a);
        bit ok = 1'b0;
        axil.AWADDR  = a;
        axil.AWVALID = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge ACLK);
            if (axil.AWREADY) ok = 1'b1;
            @(posedge ACLK); #1;
        end
        axil.AWVALID = 1'b0;
        if (!ok) check("aw_timeout", 0, 1);
    endtask

    task automatic send_w(input logic [31:0] d);
        bit ok = 1'b0;
        axil.WDATA  = d;
        axil.WVALID = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge ACLK);
            if (axil.WREADY) ok = 1'b1;
            @(posedge ACLK); #1;
        end
        axil.WVALID = 1'b0;
        if (!ok) check("w_timeout", 0, 1);
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit ok = 1'b0;
        axil.ARADDR  = a;
        axil.ARVALID = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge ACLK);
            if (axil.ARREADY) ok = 1'b1;
            @(posedge ACLK); #1;
        end
        axil.ARVALID = 1'b0;
        if (!ok) check("ar_timeout", 0, 1);
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input bit aw_lead,
                             input logic [1:0] resp);
        exp_b.push_back(resp);
        if (resp == RESP_OKAY) exp_cmd.push_back(mk_cmd(1'b1, a, d));
        fork
            send_aw(a);
            begin
                if (aw_lead) begin
                    @(posedge ACLK); #1;
                end
                send_w(d);
            end
        join
    endtask

    task automatic engine_reply(input logic [7:0] d, input logic err);
        rsp_valid = 1'b1;
        rsp_rdata = d;
        rsp_err   = err;
        @(posedge ACLK); #1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
    endtask

    task automatic wait_cmd_drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge ACLK);
            if (exp_cmd.size() == 0) break;
        end
        @(posedge ACLK); #1;
        check({tag, "_cmd_drain"}, exp_cmd.size(), 0);
    endtask

    task automatic wait_idle(input string tag, input bit incl_cmd);
        for (int i = 0; i < 300; i++) begin
            @(negedge ACLK);
            if (exp_b.size() == 0 && exp_r.size() == 0 && (!incl_cmd || exp_cmd.size() == 0)) break;
        end
        @(posedge ACLK); #1;
        check({tag, "_b_left"}, exp_b.size(), 0);
        check({tag, "_r_left"}, exp_r.size(), 0);
        if (incl_cmd) check({tag, "_cmd_left"}, exp_cmd.size(), 0);
    endtask

    task automatic read_txn(input logic [31:0] a, input logic [7:0] d, input logic err);
        logic [9:0] r;
        r = {(err ? RESP_SLVERR : RESP_OKAY), d};
        exp_cmd.push_back(mk_cmd(1'b0, a, 32'h0));
        exp_r.push_back(r);
        send_ar(a);
        wait_cmd_drain("rd");
        engine_reply(d, err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, axil.AWREADY, 0);
        check({tag, "_wready"}, axil.WREADY, 0);
        check({tag, "_arready"}, axil.ARREADY, 0);
        check({tag, "_bvalid_bresp"}, {axil.BVALID, axil.BRESP}, 0);
        check({tag, "_rvalid_rresp_rdata"}, {axil.RVALID, axil.RRESP, axil.RDATA}, 0);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_cmd_fields"}, {cmd_write, cmd_addr, cmd_wdata}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axil.AWVALID = 1'b0; axil.AWADDR = '0;
        axil.WVALID  = 1'b0; axil.WDATA  = '0;
        axil.ARVALID = 1'b0; axil.ARADDR = '0;
        axil.BREADY  = 1'b1; axil.RREADY = 1'b1;
        cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;

        #2 ARESETn = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check_all_zero("reset");
        @(negedge ACLK) ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check("readys_after_release", {axil.AWREADY, axil.WREADY, axil.ARREADY}, 3'b111);

        // AW one cycle ahead of W; BVALID appears two edges after W is held.
        write_txn(32'h4000_0010, 32'h0000_00A5, 1'b1, RESP_OKAY);
        check("wr_hit_bvalid_n", axil.BVALID, 0);
        @(posedge ACLK); #1;
        check("wr_hit_bvalid_n1", axil.BVALID, 0);
        @(posedge ACLK); #1;
        check("wr_hit_bvalid_n2", axil.BVALID, 1);
        check("wr_hit_cmd_valid", cmd_valid, 1);
        wait_idle("wr_hit", 1'b1);

        // Write outside the window: DECERR one edge after both held, nothing queued.
        write_txn(32'h5000_0000, 32'h0000_1234, 1'b0, RESP_DECERR);
        check("wr_miss_bvalid_n", axil.BVALID, 0);
        @(posedge ACLK); #1;
        check("wr_miss_bvalid_n1", axil.BVALID, 1);
        check("wr_miss_no_cmd", cmd_valid, 0);
        wait_idle("wr_miss", 1'b1);

        // Engine stalled: four writes fill the FIFO, the fifth parks in WR_QUEUE.
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            write_txn(32'h4000_0100 + 32'(4 * i), 32'h0000_0100 + 32'(i), 1'b0, RESP_OKAY);
        repeat (4) @(posedge ACLK);
        #1;
        check("full_awready_low", axil.AWREADY, 0);
        check("full_no_bvalid", axil.BVALID, 0);
        check("full_four_b_done", exp_b.size(), 1);
        cmd_ready = 1'b1;
        @(posedge ACLK); #1;
        cmd_ready = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("fifth_bresp_after_pop", exp_b.size(), 0);
        cmd_ready = 1'b1;
        wait_idle("full", 1'b1);

        // rsp_valid with no read in R_WAIT must not produce an R beat.
        engine_reply(8'hFF, 1'b1);
        repeat (3) @(posedge ACLK);
        #1;
        check("stray_rsp_ignored", axil.RVALID, 0);

        read_txn(32'h4000_0004, 8'h3C, 1'b0);
        wait_idle("rd_ok", 1'b1);
        read_txn(32'h4000_0004, 8'h5A, 1'b1);
        wait_idle("rd_err", 1'b1);

        // Read miss: DECERR with zero data one edge after AR.
        exp_r.push_back({RESP_DECERR, 8'h00});
        send_ar(32'h6000_0000);
        check("rd_miss_rvalid_n", axil.RVALID, 0);
        @(posedge ACLK); #1;
        check("rd_miss_rvalid_n1", axil.RVALID, 1);
        wait_idle("rd_miss", 1'b1);

        // Write and read both want the FIFO on the same edge: write first.
        cmd_ready = 1'b0;
        fork
            write_txn(32'h4000_0200, 32'hDEAD_BEEF, 1'b0, RESP_OKAY);
            begin
                @(posedge ACLK); #1;
                exp_cmd.push_back(mk_cmd(1'b0, 32'h4000_0208, 32'h0));
                exp_r.push_back({RESP_OKAY, 8'h77});
                send_ar(32'h4000_0208);
            end
        join
        repeat (4) @(posedge ACLK);
        #1;
        check("collide_both_queued", cmd_valid, 1);
        cmd_ready = 1'b1;
        wait_cmd_drain("collide");
        engine_reply(8'h77, 1'b0);
        wait_idle("collide", 1'b1);

        // Reset with BVALID pending and two commands queued.
        cmd_ready = 1'b0;
        write_txn(32'h4000_0300, 32'h0000_0011, 1'b0, RESP_OKAY);
        wait_idle("pre_rst1", 1'b0);
        axil.BREADY = 1'b0;
        write_txn(32'h4000_0304, 32'h0000_0022, 1'b0, RESP_OKAY);
        repeat (4) @(posedge ACLK);
        #1;
        check("pre_rst_bvalid", axil.BVALID, 1);
        check("pre_rst_two_cmds", exp_cmd.size(), 2);
        @(negedge ACLK) ARESETn = 1'b0;
        exp_cmd.delete();
        exp_b.delete();
        #1;
        check_all_zero("mid_reset");
        axil.BREADY = 1'b1;
        cmd_ready   = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK) ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check("post_rst_readys", {axil.AWREADY, axil.WREADY, axil.ARREADY}, 3'b111);
        check("post_rst_fifo_empty", cmd_valid, 0);

        write_txn(32'h4000_0400, 32'h0000_CAFE, 1'b1, RESP_OKAY);
        wait_idle("final", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
